// File: rtl/argo_chan_arb.sv
// Round-robin arbiter sharing one channel FIFO write port among NUM_REQ writers.
// Each grant is a fixed three-cycle transaction: IDLE (arbitrate) -> WRITE -> ACK.
module argo_chan_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 2,
  parameter int unsigned ARB_ID     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [IDX_WIDTH-1:0]   last_idx, last_idx_n;
  logic [IDX_WIDTH-1:0]   grant_idx_n;
  logic [DATA_WIDTH-1:0]  wr_data_n;
  logic [NUM_REQ-1:0]     ack_n;
  logic                   wr_en_n;
  logic                   busy_n;

  logic                   hi_found, lo_found;
  logic [IDX_WIDTH-1:0]   hi_idx, lo_idx;
  logic                   win_valid;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [DATA_WIDTH-1:0]  win_data;

  // Debug identifier only; kept visible without affecting logic.
  logic unused_arb_id;
  assign unused_arb_id = ^ARB_ID;

  // Round-robin pick: lowest requester above last_idx, else lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_WIDTH'(i);
        if (IDX_WIDTH'(i) > last_idx) begin
          hi_found = 1'b1;
          hi_idx   = IDX_WIDTH'(i);
        end
      end
    end
    win_valid = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Winner data select; only indices below NUM_REQ can ever match.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_WIDTH'(i) == win_idx) begin
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_n     = state;
    last_idx_n  = last_idx;
    grant_idx_n = grant_idx;
    wr_data_n   = fifo_wr_data;
    wr_en_n     = 1'b0;
    ack_n       = '0;
    busy_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (win_valid && !fifo_full) begin
          state_n     = WRITE;
          grant_idx_n = win_idx;
          wr_data_n   = win_data;
          wr_en_n     = 1'b1;
        end
      end
      WRITE: begin
        state_n = ACK;
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_n[i] = (IDX_WIDTH'(i) == grant_idx);
        end
      end
      ACK: begin
        state_n    = IDLE;
        last_idx_n = grant_idx;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_idx     <= IDX_WIDTH'(NUM_REQ - 1);
      grant_idx    <= '0;
      fifo_wr_data <= '0;
      fifo_wr_en   <= 1'b0;
      ack          <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      last_idx     <= last_idx_n;
      grant_idx    <= grant_idx_n;
      fifo_wr_data <= wr_data_n;
      fifo_wr_en   <= wr_en_n;
      ack          <= ack_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_argo_chan_arb.sv
// Scoreboard bench for argo_chan_arb: stimulus queues expected writes/acks,
// a negedge monitor pops and compares whenever the DUT writes or acks.
module tb_argo_chan_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [IW-1:0]     grant_idx;
  logic              busy;

  logic [DW-1:0]     d [NR];
  assign req_data = {d[3], d[2], d[1], d[0]};

  argo_chan_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ARB_ID(7)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_wr_t;

  exp_wr_t       wq[$];
  logic [IW-1:0] aq[$];
  int            wr_log[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every ack must match the head of its queue.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_log.push_back(cyc);
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(grant_idx), 32'hFFFF_FFFF);
      end else begin
        exp_wr_t e;
        e = wq.pop_front();
        check("wr_data", fifo_wr_data, e.data);
        check("wr_grant_idx", 32'(grant_idx), 32'(e.idx));
        check("wr_busy", 32'(busy), 32'd1);
      end
    end
    if (ack !== '0) begin
      if (aq.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        logic [IW-1:0] ei;
        logic [NR-1:0] ev;
        ei = aq.pop_front();
        ev = '0;
        ev[ei] = 1'b1;
        check("ack_vector", 32'(ack), 32'(ev));
        check("ack_grant_idx", 32'(grant_idx), 32'(ei));
      end
    end
  end

  task automatic push_txn(input logic [IW-1:0] idx, input logic [DW-1:0] data);
    exp_wr_t e;
    e.idx  = idx;
    e.data = data;
    wq.push_back(e);
    aq.push_back(idx);
  endtask

  // Returns at the negedge of the ack cycle; bounded.
  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack !== '0) seen = 1'b1;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1'b1;
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant"}, 32'(grant_idx), 32'd0);
    check({tag, "_data"}, fifo_wr_data, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) d[i] = 32'h1000_0000 + 32'(i);

    // Reset held two cycles with all writers requesting.
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset");
    end

    // Fairness from reset: 0,1,2,3,0,1 with new data after each ack.
    wr_log.delete();
    for (int k = 0; k < 6; k++) begin
      push_txn(IW'(k % 4), 32'h1000_0000 + 32'(k % 4) + ((k >= 4) ? 32'h100 : 32'h0));
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_ack();
      d[k % 4] = d[k % 4] + 32'h100;
      if (k == 5) req = 4'b0000;
    end
    check("fair_write_count", 32'(wr_log.size()), 32'd6);
    for (int i = 1; i < 6 && i < wr_log.size(); i++) begin
      check("fair_write_gap", 32'(wr_log[i] - wr_log[i-1]), 32'd3);
    end

    // Single writer latency: write at T+1, ack at T+2.
    wait_idle();
    d[0] = 32'hA5A5_A5A5;
    req  = 4'b0001;
    push_txn(2'd0, 32'hA5A5_A5A5);
    @(negedge clk);
    check("single_wr_en", 32'(fifo_wr_en), 32'd1);
    check("single_wr_data", fifo_wr_data, 32'hA5A5_A5A5);
    check("single_busy_t1", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_ack", 32'(ack), 32'b0001);
    check("single_busy_t2", 32'(busy), 32'd1);
    check("single_no_wr_in_ack", 32'(fifo_wr_en), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    check("single_busy_t3", 32'(busy), 32'd0);
    check("single_data_hold", fifo_wr_data, 32'hA5A5_A5A5);

    // Drive last_idx to 3, then 0101 must grant 0 then 2.
    wait_idle();
    d[3] = 32'h3333_3333;
    req  = 4'b1000;
    push_txn(2'd3, 32'h3333_3333);
    wait_ack();
    req = 4'b0000;
    wait_idle();
    d[0] = 32'h0505_0000;
    d[2] = 32'h0505_0002;
    req  = 4'b0101;
    push_txn(2'd0, 32'h0505_0000);
    push_txn(2'd2, 32'h0505_0002);
    wait_ack();
    wait_ack();
    req = 4'b0000;

    // Back-pressure: nothing moves while full, then normal latency.
    wait_idle();
    fifo_full = 1'b1;
    d[1] = 32'hBBBB_0001;
    req  = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      check("bp_wr_en", 32'(fifo_wr_en), 32'd0);
      check("bp_busy", 32'(busy), 32'd0);
    end
    fifo_full = 1'b0;
    push_txn(2'd1, 32'hBBBB_0001);
    @(negedge clk);
    check("bp_release_wr_en", 32'(fifo_wr_en), 32'd1);
    @(negedge clk);
    check("bp_release_ack", 32'(ack), 32'b0010);
    req = 4'b0000;

    // Reset in the WRITE cycle aborts the ack; held request is regranted.
    wait_idle();
    d[1] = 32'hCCCC_0001;
    req  = 4'b0010;
    begin
      exp_wr_t e;
      e.idx  = 2'd1;
      e.data = 32'hCCCC_0001;
      wq.push_back(e);
    end
    push_txn(2'd1, 32'hCCCC_0001);
    @(negedge clk);
    check("mid_rst_in_write", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    wait_ack();
    req = 4'b0000;

    repeat (5) @(negedge clk);
    check("wq_drained", 32'(wq.size()), 32'd0);
    check("aq_drained", 32'(aq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/argo_chan_arb.md
ARGO_CHAN_ARB -- requirements
Module: argo_chan_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of writers sharing one channel FIFO write port, range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32: channel data width; SHALL equal the downstream FIFO data width.
REQ-003 Parameter IDX_WIDTH, default 2: width of grant index; 2^IDX_WIDTH >= NUM_REQ.
REQ-004 Parameter ARB_ID, default 0: debug identifier only; no functional effect.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req  input  NUM_REQ  per-writer request; bit i = writer i.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  writer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 ack  output  NUM_REQ  one-cycle completion pulse to the granted writer.
REQ-010 fifo_full  input  1  full status from the channel FIFO.
REQ-011 fifo_wr_en  output  1  FIFO write strobe.
REQ-012 fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_idx  output  IDX_WIDTH  index of current/last granted writer.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, WRITE, ACK; all outputs registered.
REQ-016 IDLE: if any req bit set and fifo_full==0, select winner, latch its index into grant_idx and its data into fifo_wr_data, go WRITE; else stay IDLE.
REQ-017 Winner: first set req bit searching from (last_idx+1) mod NUM_REQ upward with wrap to 0.
REQ-018 WRITE: fifo_wr_en=1 for exactly this one cycle with latched data; go ACK unconditionally.
REQ-019 ACK: ack[grant_idx]=1 for exactly this one cycle, all other ack bits 0; last_idx <= grant_idx; go IDLE.
REQ-020 Latency: req sampled in IDLE cycle T -> fifo_wr_en in T+1 -> ack in T+2; peak throughput one write per 3 cycles.
REQ-021 req and fifo_full SHALL be sampled only in IDLE; changes during WRITE/ACK are ignored.
REQ-022 Writer protocol: hold req and req_data stable until ack seen, then deassert req (or present new data) on the following edge; a writer dropping req before ack SHALL still have its latched write completed and acked.
REQ-023 At most one ack bit and at most one fifo_wr_en per 3-cycle transaction; fifo_wr_en never asserted in IDLE or ACK.
REQ-024 fifo_wr_data and grant_idx hold their values outside WRITE until next grant.
REQ-025 Request bits at index >= NUM_REQ do not exist; no out-of-range grant_idx SHALL ever be produced.

Reset
REQ-026 rst high at posedge: state IDLE, last_idx=NUM_REQ-1 (writer 0 wins first), ack=0, fifo_wr_en=0, fifo_wr_data=0, grant_idx=0, busy=0.
REQ-027 rst in WRITE or ACK aborts the transaction: no further fifo_wr_en, no ack; writer retries by holding req.
REQ-028 rst dominates all other inputs in the same cycle.

Verification
REQ-029 Reset: rst=1 two cycles with req=4'b1111 -> all outputs 0, no write, first post-reset grant_idx=0.
REQ-030 Single writer: req=4'b0001, data0=0xA5A5A5A5 at IDLE cycle T -> fifo_wr_en=1, fifo_wr_data=0xA5A5A5A5 at T+1; ack=4'b0001 at T+2; busy high T+1..T+2.
REQ-031 Fairness: req=4'b1111 held continuously (new data per ack) -> grant_idx sequence 0,1,2,3,0,1; writes exactly 3 cycles apart.
REQ-032 Wrap: after last_idx=3, req=4'b0101 -> grant 0; then last_idx=0 -> grant 2.
REQ-033 Back-pressure: fifo_full=1 with req=4'b0010 for 5 cycles -> fifo_wr_en=0, busy=0; fifo_full->0 at cycle T -> fifo_wr_en at T+1, ack=4'b0010 at T+2.
REQ-034 Reset mid-operation: rst=1 in WRITE cycle of writer 1 -> no ack[1], outputs 0 next cycle; with req=4'b0010 still held, writer 1 regranted after reset.
